// File: rtl/ether_tx_arbiter.sv
// ether_tx_arbiter: two-source round-robin front end for ethernet_tx.
// Streams the owner's nibbles, pads to minimum, drains, then holds an IFG.
module ether_tx_arbiter #(
  parameter int N           = 4,
  parameter int MIN_NIBBLES = 92,
  parameter int IFG_CYCLES  = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     src_valid,
  input  logic [1:0]     src_last,
  input  logic [2*N-1:0] src_data,
  input  logic [95:0]    src_dest_mac,
  input  logic [31:0]    src_etype,
  output logic [1:0]     src_ready,
  output logic [1:0]     grant,
  output logic           tx_axiiv,
  output logic [N-1:0]   tx_axiid,
  output logic [47:0]    tx_dest_mac,
  output logic [15:0]    tx_etype,
  input  logic           tx_axiov,
  output logic           busy,
  output logic           underrun_err
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    PAD,
    DRAIN,
    GAP
  } state_t;

  localparam logic [15:0] MIN_W = 16'(MIN_NIBBLES);
  // The IDLE cycle that precedes a grant is the last gap cycle,
  // so GAP itself only has to cover IFG_CYCLES-1 of them.
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  state_t         state_q;
  logic [1:0]     grant_q;
  logic           last_q;
  logic           axiiv_q;
  logic [N-1:0]   axiid_q;
  logic [47:0]    mac_q;
  logic [15:0]    etype_q;
  logic [15:0]    cnt_q;
  logic [15:0]    gap_q;
  logic           seen_q;
  logic           uerr_q;

  logic           own_d;
  logic           win_d;
  logic           cur_valid_d;
  logic           cur_last_d;
  logic [N-1:0]   cur_data_d;
  logic [47:0]    win_mac_d;
  logic [15:0]    win_etype_d;
  logic [15:0]    cnt_inc_d;

  // Owner selection and the winner's header fields.
  always_comb begin
    own_d       = grant_q[1];
    win_d       = (src_valid == 2'b11) ? ~last_q : src_valid[1];
    cur_valid_d = own_d ? src_valid[1] : src_valid[0];
    cur_last_d  = own_d ? src_last[1] : src_last[0];
    cur_data_d  = own_d ? src_data[2*N-1:N] : src_data[N-1:0];
    win_mac_d   = win_d ? src_dest_mac[95:48] : src_dest_mac[47:0];
    win_etype_d = win_d ? src_etype[31:16] : src_etype[15:0];
    cnt_inc_d   = cnt_q + 16'd1;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      axiiv_q <= 1'b0;
      axiid_q <= '0;
      mac_q   <= '0;
      etype_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      seen_q  <= 1'b0;
      uerr_q  <= 1'b0;
    end else begin
      uerr_q <= 1'b0;
      if ((state_q inside {SEND, PAD, DRAIN}) && tx_axiov)
        seen_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          axiiv_q <= 1'b0;
          if (|src_valid) begin
            grant_q <= win_d ? 2'b10 : 2'b01;
            last_q  <= win_d;
            mac_q   <= win_mac_d;
            etype_q <= win_etype_d;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (cur_valid_d) begin
            axiiv_q <= 1'b1;
            axiid_q <= cur_data_d;
            cnt_q   <= cnt_inc_d;
            if (cur_last_d)
              state_q <= (cnt_inc_d < MIN_W) ? PAD : DRAIN;
          end else begin
            axiiv_q <= 1'b0;
            uerr_q  <= 1'b1;
            state_q <= DRAIN;
          end
        end
        PAD: begin
          axiiv_q <= 1'b1;
          axiid_q <= '0;
          cnt_q   <= cnt_inc_d;
          if (cnt_inc_d >= MIN_W)
            state_q <= DRAIN;
        end
        DRAIN: begin
          axiiv_q <= 1'b0;
          if (seen_q && !tx_axiov) begin
            grant_q <= 2'b00;
            gap_q   <= 16'd1;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q >= IFG_LAST)
            state_q <= IDLE;
          else
            gap_q <= gap_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_ready    = (state_q == SEND) ? grant_q : 2'b00;
  assign grant        = grant_q;
  assign tx_axiiv     = axiiv_q;
  assign tx_axiid     = axiid_q;
  assign tx_dest_mac  = mac_q;
  assign tx_etype     = etype_q;
  assign busy         = (state_q != IDLE);
  assign underrun_err = uerr_q;

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// tb_ether_tx_arbiter: directed bench for ether_tx_arbiter.
// Sources and an ethernet_tx axiov stand-in are modelled here.
module tb_ether_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  src_valid = '0;
  logic [1:0]  src_last = '0;
  logic [7:0]  src_data = '0;
  logic [95:0] src_dest_mac;
  logic [31:0] src_etype;
  logic [1:0]  src_ready;
  logic [1:0]  grant;
  logic        tx_axiiv;
  logic [3:0]  tx_axiid;
  logic [47:0] tx_dest_mac;
  logic [15:0] tx_etype;
  logic        tx_axiov;
  logic        busy;
  logic        underrun_err;

  localparam logic [47:0] MAC0 = 48'hFE_DC_BA_98_76_54;
  localparam logic [15:0] ET0  = 16'h6789;
  localparam logic [47:0] MAC1 = 48'h0A_1B_2C_3D_4E_5F;
  localparam logic [15:0] ET1  = 16'h88B5;

  ether_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_last(src_last),
    .src_data(src_data), .src_dest_mac(src_dest_mac),
    .src_etype(src_etype), .src_ready(src_ready),
    .grant(grant), .tx_axiiv(tx_axiiv),
    .tx_axiid(tx_axiid), .tx_dest_mac(tx_dest_mac),
    .tx_etype(tx_etype), .tx_axiov(tx_axiov),
    .busy(busy), .underrun_err(underrun_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // source models
  int rem[2];
  int len[2];
  int nfr[2];
  int idx[2];
  int drop[2];
  logic [1:0] acc = '0;
  logic [3:0] sbq[$];

  task automatic drive_src(input bit s);
    bit v;
    if (acc[s] && rem[s] > 0) begin
      rem[s]--;
      idx[s]++;
      if (rem[s] == 0 && nfr[s] > 0) begin
        nfr[s]--;
        rem[s] = len[s];
        idx[s] = 0;
      end
    end
    v = (rem[s] > 0) && (drop[s] < 0 || idx[s] < drop[s]);
    src_valid[s] = v;
    src_last[s] = v && (rem[s] == 1);
    if (s == 1'b0)
      src_data[3:0] = 4'((idx[s] % 15) + 1);
    else
      src_data[7:4] = 4'(15 - (idx[s] % 15));
  endtask

  always @(negedge clk) begin
    drive_src(1'b0);
    drive_src(1'b1);
  end

  // accepted beats feed the data scoreboard
  always @(posedge clk) begin
    if (rst) begin
      acc = '0;
      sbq.delete();
    end else begin
      acc = src_valid & src_ready;
      if (acc[0]) sbq.push_back(src_data[3:0]);
      if (acc[1]) sbq.push_back(src_data[7:4]);
    end
  end

  // ethernet_tx stand-in: axiov follows axiiv plus an 8-cycle tail
  logic [3:0] tail;
  always @(posedge clk) begin
    if (rst) begin
      tx_axiov <= 1'b0;
      tail <= '0;
    end else if (tx_axiiv) begin
      tx_axiov <= 1'b1;
      tail <= 4'd8;
    end else if (tail != 0) begin
      tail <= tail - 4'd1;
    end else begin
      tx_axiov <= 1'b0;
    end
  end

  // monitor
  int cyc = 0, run = 0, zrun = 0, ovfall = 0, rdyrise = 0;
  int runs[$], gzero[$], dlt[$], lat[$];
  logic [1:0]  gev[$];
  logic [47:0] macs[$];
  logic [15:0] ets[$];
  int uerr_n = 0, uerr_fall = 0, macchg = 0;
  logic [1:0]  gprev = '0, rprev = '0;
  logic        ovprev = 1'b0, ivprev = 1'b0;
  logic [47:0] mprev = '0;
  logic [15:0] eprev = '0;

  always @(negedge clk) begin
    logic [3:0] e;
    cyc++;
    if (src_ready != 0 && rprev == 0) rdyrise = cyc;
    if (tx_axiiv === 1'b1) begin
      if (!ivprev) lat.push_back(cyc - rdyrise);
      run++;
      e = (sbq.size() > 0) ? sbq.pop_front() : 4'h0;
      chk("txd", 64'(tx_axiid), 64'(e));
    end else if (run != 0) begin
      runs.push_back(run);
      if (underrun_err === 1'b1) uerr_fall++;
      run = 0;
    end
    if (underrun_err === 1'b1) uerr_n++;
    if (!tx_axiov && ovprev) ovfall = cyc;
    if (grant != 0 && gprev == 0) begin
      gev.push_back(grant);
      gzero.push_back(zrun);
      macs.push_back(tx_dest_mac);
      ets.push_back(tx_etype);
    end
    if (grant != 0 && gprev != 0 &&
        (tx_dest_mac != mprev || tx_etype != eprev))
      macchg++;
    if (gprev != 0 && grant == 0) dlt.push_back(cyc - ovfall);
    if (grant == 0) zrun++;
    else zrun = 0;
    gprev = grant;
    rprev = src_ready;
    ovprev = tx_axiov;
    ivprev = tx_axiiv;
    mprev = tx_dest_mac;
    eprev = tx_etype;
  end

  task automatic clear_mon();
    runs.delete(); gzero.delete(); dlt.delete(); lat.delete();
    gev.delete(); macs.delete(); ets.delete();
    uerr_n = 0; uerr_fall = 0; macchg = 0;
  endtask

  task automatic load(input bit s, input int n, input int extra,
                      input int dr);
    rem[s] = n; len[s] = n; nfr[s] = extra;
    idx[s] = 0; drop[s] = dr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) load(i[0], 0, 0, -1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic chk_rstv(input string p);
    chk({p, "_gnt"}, 64'(grant), 64'(0));
    chk({p, "_iv"}, 64'(tx_axiiv), 64'(0));
    chk({p, "_id"}, 64'(tx_axiid), 64'(0));
    chk({p, "_mac"}, 64'(tx_dest_mac), 64'(0));
    chk({p, "_et"}, 64'(tx_etype), 64'(0));
    chk({p, "_busy"}, 64'(busy), 64'(0));
    chk({p, "_uerr"}, 64'(underrun_err), 64'(0));
    chk({p, "_rdy"}, 64'(src_ready), 64'(0));
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while ((busy || src_valid != 0 || run != 0) && t < 3000);
    chk(tag, 64'(t >= 3000), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    src_dest_mac = {MAC1, MAC0};
    src_etype = {ET1, ET0};
    for (int i = 0; i < 2; i++) load(i[0], 0, 0, -1);

    // reset values
    do_reset();
    chk_rstv("r0");

    // single source 0, 100 beats
    load(1'b0, 100, 0, -1);
    wait_idle("t1_tmo");
    chk("t1_nrun", 64'(runs.size()), 64'(1));
    chk("t1_run", 64'(runs[0]), 64'(100));
    chk("t1_gnt", 64'(gev[0]), 64'(1));
    chk("t1_mac", 64'(macs[0]), 64'(MAC0));
    chk("t1_et", 64'(ets[0]), 64'(ET0));
    chk("t1_stable", 64'(macchg), 64'(0));
    chk("t1_lat", 64'(lat[0]), 64'(1));
    chk("t1_drain", 64'(dlt[0]), 64'(1));
    chk("t1_uerr", 64'(uerr_n), 64'(0));

    // source 1, 10 beats padded to 92
    do_reset();
    load(1'b1, 10, 0, -1);
    wait_idle("t2_tmo");
    chk("t2_nrun", 64'(runs.size()), 64'(1));
    chk("t2_run", 64'(runs[0]), 64'(92));
    chk("t2_gnt", 64'(gev[0]), 64'(2));
    chk("t2_mac", 64'(macs[0]), 64'(MAC1));
    chk("t2_et", 64'(ets[0]), 64'(ET1));
    chk("t2_lat", 64'(lat[0]), 64'(1));

    // both sources, round robin 0,1,0
    do_reset();
    load(1'b0, 100, 1, -1);
    load(1'b1, 100, 0, -1);
    wait_idle("t3_tmo");
    chk("t3_ng", 64'(gev.size()), 64'(3));
    chk("t3_g0", 64'(gev[0]), 64'(1));
    chk("t3_g1", 64'(gev[1]), 64'(2));
    chk("t3_g2", 64'(gev[2]), 64'(1));
    chk("t3_gap1", 64'(gzero[1]), 64'(24));
    chk("t3_gap2", 64'(gzero[2]), 64'(24));
    chk("t3_r0", 64'(runs[0]), 64'(100));
    chk("t3_r1", 64'(runs[1]), 64'(100));
    chk("t3_r2", 64'(runs[2]), 64'(100));
    chk("t3_d0", 64'(dlt[0]), 64'(1));
    chk("t3_d1", 64'(dlt[1]), 64'(1));
    chk("t3_d2", 64'(dlt[2]), 64'(1));
    chk("t3_mac1", 64'(macs[1]), 64'(MAC1));
    chk("t3_stable", 64'(macchg), 64'(0));

    // underrun on source 0 at beat 50, then source 1
    do_reset();
    load(1'b0, 200, 0, 50);
    load(1'b1, 20, 0, -1);
    wait_idle("t4_tmo");
    chk("t4_nrun", 64'(runs.size()), 64'(2));
    chk("t4_r0", 64'(runs[0]), 64'(50));
    chk("t4_r1", 64'(runs[1]), 64'(92));
    chk("t4_uerr_n", 64'(uerr_n), 64'(1));
    chk("t4_uerr_at", 64'(uerr_fall), 64'(1));
    chk("t4_g0", 64'(gev[0]), 64'(1));
    chk("t4_g1", 64'(gev[1]), 64'(2));
    chk("t4_gap", 64'(gzero[1]), 64'(24));
    chk("t4_d0", 64'(dlt[0]), 64'(1));

    // reset during beat 40
    do_reset();
    load(1'b0, 100, 0, -1);
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (run < 40 && t < 500);
    chk("t5_tmo", 64'(t >= 500), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    load(1'b1, 20, 0, -1);
    @(negedge clk);
    chk_rstv("t5");
    @(posedge clk);
    #1;
    clear_mon();
    wait_idle("t5_tmo2");
    chk("t5_g0", 64'(gev[0]), 64'(1));
    chk("t5_g1", 64'(gev[1]), 64'(2));
    chk("t5_r0", 64'(runs[0]), 64'(92));
    chk("t5_r1", 64'(runs[1]), 64'(92));

    // re-request during GAP
    do_reset();
    load(1'b0, 10, 0, -1);
    t = 0;
    while (grant == 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    while (grant != 0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("t6_tmo", 64'(t >= 1000), 64'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("t6_busy", 64'(busy), 64'(1));
    chk("t6_gnt0", 64'(grant), 64'(0));
    load(1'b0, 10, 0, -1);
    wait_idle("t6_tmo2");
    chk("t6_ng", 64'(gev.size()), 64'(2));
    chk("t6_g1", 64'(gev[1]), 64'(1));
    chk("t6_gap", 64'(gzero[1]), 64'(24));
    chk("t6_r1", 64'(runs[1]), 64'(92));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ether_tx_arbiter.md
Name: ether_tx_arbiter

Overview:
- Two-requester round-robin scheduler in front of ethernet_tx.
- Grants one source at a time and streams its nibble payload onto ethernet_tx's axiiv/axiid input.
- Presents that source's dest_mac/etype to ethernet_tx for the whole frame.
- Zero-pads short payloads to the Ethernet minimum, waits for the frame (incl. CRC) to drain via axiov, then enforces an inter-frame gap before the next grant.

Parameters:
N, 4, nibble/data width shared with ethernet_tx
MIN_NIBBLES, 92, minimum payload length in N-bit beats (46 bytes at N=4)
IFG_CYCLES, 24, idle cycles between end of drain and next grant (12 bytes at N=4)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
src_valid  input  2  per-source beat valid (bit i = source i)
src_last  input  2  per-source final payload beat marker
src_data  input  2*N  per-source beat; source i at [i*N +: N]
src_dest_mac  input  96  per-source destination MAC; source i at [i*48 +: 48]
src_etype  input  32  per-source ethertype; source i at [i*16 +: 16]
src_ready  output  2  beat accepted for source i (combinational)
grant  output  2  one-hot current owner; 0 when idle/gap
tx_axiiv  output  1  to ethernet_tx axiiv
tx_axiid  output  N  to ethernet_tx axiid
tx_dest_mac  output  48  to ethernet_tx dest_mac
tx_etype  output  16  to ethernet_tx etype
tx_axiov  input  1  monitored ethernet_tx axiov
busy  output  1  high in any state except IDLE
underrun_err  output  1  one-cycle pulse on mid-frame starvation

Behaviour:
- Reset: state=IDLE. grant=0, tx_axiiv=0, tx_axiid=0, tx_dest_mac=0, tx_etype=0, busy=0, underrun_err=0. last_grant=1, so source 0 wins the first tie. Beat count=0, gap count=0, seen_ov=0.
- Reset mid-frame aborts immediately. tx_axiiv=0 on the next edge, with no padding and no drain wait.
- Request = src_valid[i] while in IDLE.
- IDLE: if any request, pick the winner.
  - Both requesting: winner = source != last_grant.
  - Otherwise the single requester wins.
  - Register grant, last_grant=winner, and tx_dest_mac/tx_etype from the winner's slice.
  - Go to SEND.
- tx_dest_mac/tx_etype hold until the next grant. They are stable for the whole frame.
- SEND: src_ready = grant (combinational); other source's ready=0.
  - Each cycle with src_valid[g]: tx_axiiv<=1, tx_axiid<=src_data[g], count++. One-cycle registered latency from src to tx.
  - Beat with src_last[g]:
    - count+1 < MIN_NIBBLES -> PAD.
    - Otherwise tx_axiiv<=0 next -> DRAIN.
  - src_valid[g]=0 after at least one beat accepted = underrun. tx_axiiv<=0, underrun_err pulses 1 cycle, go to DRAIN, no padding.
  - Before the first beat, an idle src_valid is impossible (grant issued on valid). Invalid cycles are treated per the underrun rule.
- PAD: src_ready=0. tx_axiiv=1, tx_axiid=0 each cycle until the total beats emitted = MIN_NIBBLES, then tx_axiiv<=0 -> DRAIN. Transmitted tx_axiiv high-time is exactly max(payload, MIN_NIBBLES) cycles, contiguous.
- DRAIN: tx_axiiv=0.
  - seen_ov is sticky-set whenever tx_axiov=1 since entering SEND.
  - Exit to GAP on the first cycle with seen_ov=1 and tx_axiov=0.
  - tx_axiov already high on entry is counted. Waiting is unbounded.
- GAP: grant=0, busy=1. Count IFG_CYCLES cycles, then IDLE. No new grant is issued before the count completes, even if requests are pending.
- Count width: 16 bits. Payloads above 65535 beats are unsupported.
- src_last asserted with src_valid=0 is ignored.
- A source dropping valid in IDLE/GAP has no effect; sources are not obliged to hold.

Test Plan:
- Single source 0, 100-beat payload 0x1..0xF repeating, dest FE_DC_BA_98_76_54, etype 6789 -> grant=01, tx_axiiv high exactly 100 contiguous cycles starting 1 cycle after first src_ready. tx_axiid matches src_data delayed 1. tx_dest_mac/etype stable throughout.
- Source 1, 10-beat payload -> 10 data beats then 82 zero beats, tx_axiiv high 92 cycles total, single contiguous burst.
- Both sources valid from reset, 100 beats each -> source 0 first, then source 1, then source 0. After each frame, DRAIN exits when tx_axiov falls, followed by exactly 24 cycles with grant=0 before the next grant.
- Source 0 drops src_valid at beat 50 -> underrun_err one pulse, tx_axiiv falls next cycle, no padding, arbiter proceeds to DRAIN/GAP, then serves source 1.
- Assert rst for one cycle during beat 40 of a frame -> next cycle grant=0, tx_axiiv=0, busy=0, all outputs at reset values. Subsequent requests start with source 0 priority.
- Source 0 requests again during GAP while source 1 idle -> no grant until GAP completes, then source 0 granted (sole requester).
